// File: rtl/tl_pkg.sv
// Shared definitions for the two-road traffic phase sequencer: state codes,
// light encodings and a small classification helper.
package tl_pkg;

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALL_RED_1   = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_2   = 3'd6
  } tl_state_t;

  // Light words are {red, yellow, green}, exactly one bit set.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int unsigned TL_N = 11;

  // Timed phases are every legal state except INIT.
  function automatic logic is_timed(input tl_state_t s);
    logic r;
    r = 1'b0;
    case (s)
      MAIN_GREEN, MAIN_YELLOW, ALL_RED_1,
      SIDE_GREEN, SIDE_YELLOW, ALL_RED_2: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tl_duration_select.sv
// Picks the duration of the phase about to be entered and converts it to the
// counter preload value dur-1, saturating so a zero duration acts as one tick.
module tl_duration_select
  import tl_pkg::*;
#(
  parameter int N = TL_N
) (
  input  tl_state_t      next_state,
  input  logic [N-1:0]   t_main_green,
  input  logic [N-1:0]   t_side_green,
  input  logic [N-1:0]   t_yellow,
  input  logic [N-1:0]   t_all_red,
  output logic [N-1:0]   load_value
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] dur;

  always_comb begin
    dur = '0;
    case (next_state)
      MAIN_GREEN:               dur = t_main_green;
      MAIN_YELLOW, SIDE_YELLOW: dur = t_yellow;
      ALL_RED_1, ALL_RED_2:     dur = t_all_red;
      SIDE_GREEN:               dur = t_side_green;
      default:                  dur = '0;
    endcase
  end

  always_comb begin
    load_value = '0;
    if (dur != '0) begin
      load_value = dur - ONE;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Six-phase main/side road light controller that times each phase with an
// external down-counting parallel-load counter.
module traffic_phase_sequencer
  import tl_pkg::*;
#(
  parameter int N = TL_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         side_req,
  input  logic [N-1:0] t_main_green,
  input  logic [N-1:0] t_side_green,
  input  logic [N-1:0] t_yellow,
  input  logic [N-1:0] t_all_red,
  input  logic [N-1:0] cnt_out,
  output logic         cnt_load,
  output logic         cnt_en,
  output logic         cnt_dir,
  output logic [N-1:0] cnt_value,
  output logic [2:0]   main_light,
  output logic [2:0]   side_light,
  output logic [2:0]   phase,
  output logic         req_pending
);

  // Counter strobe protocol: cnt_load and cnt_en are never high together.
  // cnt_load with cnt_value is taken by the counter on the next rising edge;
  // cnt_en alone decrements it on that edge. The phase ends on the tick that
  // finds cnt_out==0, so a preload of dur-1 yields exactly max(dur,1) ticks.

  tl_state_t state;
  tl_state_t next_state;
  logic      expire;
  logic      clear_req;

  assign expire = tick && (cnt_out == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Request is consumed when side green is actually granted.
  assign clear_req = (state == ALL_RED_1) && expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pending <= 1'b0;
    end else if (clear_req) begin
      req_pending <= 1'b0;
    end else if (side_req) begin
      req_pending <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    if (state == INIT) begin
      cnt_load   = 1'b1;
      next_state = MAIN_GREEN;
    end else if (is_timed(state)) begin
      cnt_load = expire;
      cnt_en   = tick && !expire;
      if (expire) begin
        case (state)
          MAIN_GREEN:  next_state = req_pending ? MAIN_YELLOW : MAIN_GREEN;
          MAIN_YELLOW: next_state = ALL_RED_1;
          ALL_RED_1:   next_state = SIDE_GREEN;
          SIDE_GREEN:  next_state = SIDE_YELLOW;
          SIDE_YELLOW: next_state = ALL_RED_2;
          ALL_RED_2:   next_state = MAIN_GREEN;
          default:     next_state = INIT;
        endcase
      end
    end else begin
      // Unreachable code 7 recovers through INIT, which reloads the counter.
      next_state = INIT;
    end
  end

  tl_duration_select #(
    .N (N)
  ) u_duration_select (
    .next_state   (next_state),
    .t_main_green (t_main_green),
    .t_side_green (t_side_green),
    .t_yellow     (t_yellow),
    .t_all_red    (t_all_red),
    .load_value   (cnt_value)
  );

  assign cnt_dir = 1'b1;
  assign phase   = state;

  always_comb begin
    main_light = RED;
    side_light = RED;
    case (state)
      MAIN_GREEN:  main_light = GRN;
      MAIN_YELLOW: main_light = YEL;
      SIDE_GREEN:  side_light = GRN;
      SIDE_YELLOW: side_light = YEL;
      default: begin
        main_light = RED;
        side_light = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: external counter, phase-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_traffic_phase_sequencer;

  localparam int N = 11;

  // ---------------- clock / reset / inputs ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b1;
  logic         side_req = 1'b0;
  logic [N-1:0] t_main_green = 11'd5;
  logic [N-1:0] t_side_green = 11'd3;
  logic [N-1:0] t_yellow     = 11'd2;
  logic [N-1:0] t_all_red    = 11'd1;
  logic [N-1:0] cnt_out = '0;
  logic         cnt_load, cnt_en, cnt_dir;
  logic [N-1:0] cnt_value;
  logic [2:0]   main_light, side_light, phase;
  logic         req_pending;

  always #5 clk = ~clk;

  traffic_phase_sequencer #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .side_req     (side_req),
    .t_main_green (t_main_green),
    .t_side_green (t_side_green),
    .t_yellow     (t_yellow),
    .t_all_red    (t_all_red),
    .cnt_out      (cnt_out),
    .cnt_load     (cnt_load),
    .cnt_en       (cnt_en),
    .cnt_dir      (cnt_dir),
    .cnt_value    (cnt_value),
    .main_light   (main_light),
    .side_light   (side_light),
    .phase        (phase),
    .req_pending  (req_pending)
  );

  // External up/down parallel-load counter; deliberately not reset by rst.
  always @(posedge clk) begin
    if (cnt_load) cnt_out <= cnt_value;
    else if (cnt_en) cnt_out <= cnt_dir ? cnt_out - 11'd1 : cnt_out + 11'd1;
  end

  // Tick generator: one tick every tick_div cycles.
  int tick_div = 1;
  int tick_cnt = 0;
  always begin
    @(posedge clk);
    #1;
    tick = (tick_div <= 1) ? 1'b1 : (tick_cnt % tick_div == 0);
    tick_cnt = tick_cnt + 1;
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase numbering follows the published state codes; m_rem is the number
  // of ticks still owed to the current phase, counting the present one.
  int m_ph = 0;
  int m_rem = 1;
  bit m_req = 0;
  bit m_known = 0;
  bit m_active = 0;

  function automatic int dur_of(input int ph);
    int d;
    case (ph)
      1:       d = int'(t_main_green);
      2, 5:    d = int'(t_yellow);
      3, 6:    d = int'(t_all_red);
      4:       d = int'(t_side_green);
      default: d = 1;
    endcase
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int next_of(input int ph, input bit req);
    case (ph)
      0:       return 1;
      1:       return req ? 2 : 1;
      6:       return 1;
      default: return ph + 1;
    endcase
  endfunction

  function automatic int main_of(input int ph);
    return (ph == 1) ? 1 : (ph == 2) ? 2 : 4;
  endfunction

  function automatic int side_of(input int ph);
    return (ph == 4) ? 1 : (ph == 5) ? 2 : 4;
  endfunction

  always @(posedge clk) begin
    bit ex;
    bit clr;
    int nx;
    if (rst) begin
      m_ph = 0; m_req = 0; m_known = 0; m_active = 1;
    end else if (m_active) begin
      ex  = (m_ph != 0) && tick && (m_rem == 1);
      clr = (m_ph == 3) && ex;
      nx  = next_of(m_ph, m_req);
      if (clr) m_req = 0;
      else if (side_req) m_req = 1;
      if (m_ph == 0) begin
        m_ph = 1; m_rem = dur_of(1); m_known = 1;
      end else if (ex) begin
        m_ph = nx; m_rem = dur_of(nx);
      end else if (tick) begin
        m_rem = m_rem - 1;
      end
    end
  end

  // Compare process: every cycle once reset has been seen.
  always @(negedge clk) begin
    bit e_load;
    bit e_en;
    if (m_active) begin
      e_load = (m_ph == 0) || (tick && m_rem == 1);
      e_en   = (m_ph != 0) && tick && (m_rem != 1);
      chk("phase", int'(phase), m_ph);
      chk("main_light", int'(main_light), main_of(m_ph));
      chk("side_light", int'(side_light), side_of(m_ph));
      chk("req_pending", int'(req_pending), int'(m_req));
      chk("cnt_load", int'(cnt_load), int'(e_load));
      chk("cnt_en", int'(cnt_en), int'(e_en));
      chk("cnt_dir", int'(cnt_dir), 1);
      if (e_load) chk("cnt_value", int'(cnt_value), dur_of(next_of(m_ph, m_req)) - 1);
      if (m_known) chk("cnt_out", int'(cnt_out), m_rem - 1);
    end
  end

  // Load-value capture for the literal sequence checks.
  bit cap_en = 0;
  logic [N-1:0] cap_q[$];
  logic [N-1:0] exp_q[$];
  always @(negedge clk) begin
    if (cap_en && cnt_load) cap_q.push_back(cnt_value);
  end

  task automatic check_cap(input string name);
    chk({name, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      chk(name, int'(cap_q[i]), int'(exp_q[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_phase(input int code, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (int'(phase) != code && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(phase), code);
  endtask

  // Entered at the negedge of a phase's first cycle; leaves at the negedge
  // of the following phase's first cycle.
  task automatic measure(input int code, input int exp_len, input string name);
    int n;
    n = 0;
    while (int'(phase) == code && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, exp_len);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int loads;
    logic [N-1:0] seen_q[$];

    // 1: reset, INIT for one cycle, then repeating 5-tick main green.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t1_init_phase", int'(phase), 0);
    chk("t1_init_load", int'(cnt_load), 1);
    chk("t1_init_value", int'(cnt_value), 4);
    chk("t1_init_main", int'(main_light), 4);
    chk("t1_init_side", int'(side_light), 4);
    loads = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("t1_mg_phase", int'(phase), 1);
      if (cnt_load) begin
        loads++;
        chk("t1_mg_reload", int'(cnt_value), 4);
      end
    end
    chk("t1_load_count", loads, 3);

    // 2: request pulse on the 2nd main-green cycle -> full side cycle.
    @(posedge clk);
    @(posedge clk);
    #1 side_req = 1'b1;
    cap_q.delete();
    cap_en = 1'b1;
    @(posedge clk);
    #1 side_req = 1'b0;
    @(negedge clk);
    chk("t2_req_latched", int'(req_pending), 1);
    measure(1, 3, "t2_mg_rest");   // cycles 3..5 of a 5-tick green
    measure(2, 2, "t2_my_len");
    measure(3, 1, "t2_ar1_len");
    chk("t2_req_cleared", int'(req_pending), 0);
    measure(4, 3, "t2_sg_len");
    measure(5, 2, "t2_sy_len");
    measure(6, 1, "t2_ar2_len");
    chk("t2_back_mg", int'(phase), 1);
    cap_en = 1'b0;
    exp_q = '{11'd1, 11'd0, 11'd2, 11'd1, 11'd0, 11'd4};
    check_cap("t2_load_seq");

    // 3: tick every 4th cycle stretches main green to 20 cycles.
    tick_div = 4;
    n = 0;
    while (!(int'(phase) == 1 && cnt_load) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_sync", int'(cnt_load), 1);
    @(negedge clk);
    n = 0;
    while (!cnt_load && n < 100) begin
      if (tick) seen_q.push_back(cnt_out);
      n++;
      @(negedge clk);
    end
    seen_q.push_back(cnt_out);
    n++;
    chk("t3_mg_cycles", n, 20);
    exp_q = '{11'd4, 11'd3, 11'd2, 11'd1, 11'd0};
    chk("t3_tick_count", seen_q.size(), 5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++) chk("t3_cnt_step", int'(seen_q[i]), int'(exp_q[i]));
    tick_div = 1;

    // 4: zero yellow / all-red durations behave as one tick each.
    @(posedge clk);
    #1 side_req = 1'b1;
    t_yellow = '0;
    t_all_red = '0;
    cap_q.delete();
    cap_en = 1'b1;
    @(posedge clk);
    #1 side_req = 1'b0;
    wait_phase(2, "t4_reach_my");
    measure(2, 1, "t4_my_len");
    measure(3, 1, "t4_ar1_len");
    cap_en = 1'b0;
    exp_q = '{11'd0, 11'd0, 11'd2};
    check_cap("t4_load_seq");

    // 5: reset mid side green with a request pending.
    @(posedge clk);
    #1 side_req = 1'b1;
    t_yellow = 11'd2;
    t_all_red = 11'd1;
    @(posedge clk);
    #1 side_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_pre_phase", int'(phase), 4);
    chk("t5_pre_req", int'(req_pending), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_init_phase", int'(phase), 0);
    chk("t5_init_main", int'(main_light), 4);
    chk("t5_init_side", int'(side_light), 4);
    chk("t5_init_req", int'(req_pending), 0);
    chk("t5_init_value", int'(cnt_value), 4);
    @(negedge clk);
    chk("t5_mg_phase", int'(phase), 1);

    // 6: request held across the grant edge is cleared; later pulse re-arms.
    @(posedge clk);
    #1 side_req = 1'b1;
    @(posedge clk);
    #1 side_req = 1'b0;
    wait_phase(2, "t6_reach_my");
    wait_phase(3, "t6_reach_ar1");
    side_req = 1'b1;
    @(posedge clk);
    #1 side_req = 1'b0;
    @(negedge clk);
    chk("t6_sg_phase", int'(phase), 4);
    chk("t6_clear_wins", int'(req_pending), 0);
    @(posedge clk);
    #1 side_req = 1'b1;
    @(posedge clk);
    #1 side_req = 1'b0;
    @(negedge clk);
    chk("t6_rearmed", int'(req_pending), 1);
    wait_phase(1, "t6_reach_mg");
    measure(1, 5, "t6_mg_len");
    chk("t6_served_again", int'(phase), 2);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Six-phase two-road traffic light controller: main road and side road.
- Drives the external up/down parallel-load counter through its load, enable, direction and load-value pins, and reads back the counter output.
- Counts down each phase duration and advances phases on expiry.
- Side-road green is served only after a side request; otherwise main green repeats.

Parameters:
N, 11, width of the counter, of the duration inputs and of cnt_value/cnt_out

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
tick  input  1  one-cycle timebase strobe (e.g. 1 Hz prescaler); the counter decrements only on tick
side_req  input  1  side-road vehicle/pedestrian request, level or pulse
t_main_green  input  N  main green duration in ticks
t_side_green  input  N  side green duration in ticks
t_yellow  input  N  yellow duration in ticks, both roads
t_all_red  input  N  all-red clearance duration in ticks
cnt_out  input  N  current external counter value
cnt_load  output  1  counter parallel-load strobe
cnt_en  output  1  counter enable
cnt_dir  output  1  counter direction, 1 = down; constant 1
cnt_value  output  N  counter parallel-load value
main_light  output  3  {red,yellow,green}, one-hot
side_light  output  3  {red,yellow,green}, one-hot
phase  output  3  current state code
req_pending  output  1  latched side request

Behaviour:
- States and codes:
  - INIT=0
  - MAIN_GREEN=1
  - MAIN_YELLOW=2
  - ALL_RED_1=3
  - SIDE_GREEN=4
  - SIDE_YELLOW=5
  - ALL_RED_2=6
  - Code 7 is illegal and goes to INIT.
- Reset: rst=1 at an edge gives phase=INIT, req_pending=0, main_light=side_light=100. rst mid-phase aborts immediately; the counter is not reset, INIT reloads it.
- Lights per state:
  - INIT, ALL_RED_1, ALL_RED_2: main=100, side=100.
  - MAIN_GREEN: main=001, side=100.
  - MAIN_YELLOW: main=010, side=100.
  - SIDE_GREEN: main=100, side=001.
  - SIDE_YELLOW: main=100, side=010.
- Lights and phase are decoded from the state register only (Moore).
- Load value: duration of the phase being entered, minus 1, saturating at 0. A duration of 0 behaves as 1.
- Duration inputs are sampled only in the cycle cnt_load=1.
- INIT: cnt_load=1 unconditionally (no tick needed); cnt_value=sat(t_main_green-1); next state MAIN_GREEN.
- Timed states:
  - expire = tick & (cnt_out==0).
  - cnt_en = tick & ~expire.
  - cnt_load = expire.
  - cnt_load, cnt_en and cnt_value are combinational from the state, cnt_out and tick.
  - The counter registers the load on the next edge, so each phase lasts exactly max(dur,1) ticks.
- Transitions on expire:
  - MAIN_GREEN: to MAIN_YELLOW if req_pending, else stay in MAIN_GREEN and reload t_main_green.
  - MAIN_YELLOW to ALL_RED_1.
  - ALL_RED_1 to SIDE_GREEN.
  - SIDE_GREEN to SIDE_YELLOW.
  - SIDE_YELLOW to ALL_RED_2.
  - ALL_RED_2 to MAIN_GREEN.
  - No transition without expire.
- req_pending:
  - Set by side_req in any non-reset cycle.
  - Cleared on the ALL_RED_1 to SIDE_GREEN transition edge; clear wins over a simultaneous side_req.
  - side_req during SIDE_GREEN, SIDE_YELLOW or ALL_RED_2 sets it, to be served after the next MAIN_GREEN expiry.
- A request arriving mid-MAIN_GREEN does not shorten the green; it waits for expiry.
- tick while in INIT is ignored.
- cnt_dir is held at 1 always.

Decomposition:
- Shared package tl_pkg holds:
  - state code constants (INIT..ALL_RED_2);
  - light encodings RED=3'b100, YEL=3'b010, GRN=3'b001.
- One natural sub-module: tl_duration_select.
  - Combinational.
  - Takes the next-state code and the four durations; returns the saturating dur-1 load value.
- The state register, req_pending and transition logic live in the top.

Test Plan:
(Bench: N=11, tick=1 every cycle unless stated, MG=5, SG=3, Y=2, AR=1, the team's up/down parallel-load counter wired in.)
1. rst 2 cycles then release, side_req=0 -> INIT 1 cycle, cnt_value=4; MAIN_GREEN held indefinitely; cnt_load=1 with value 4 every 5 cycles; main=001, side=100.
2. side_req pulse on 2nd MAIN_GREEN cycle -> MG 5, MY 2, AR1 1, SG 3, SY 2, AR2 1, then MG. req_pending falls at SIDE_GREEN entry. Loaded values 1,0,2,1,0,4 in that order.
3. tick every 4th cycle, no request -> MAIN_GREEN lasts 20 cycles. cnt_en high only on tick cycles; cnt_out steps 4,3,2,1,0.
4. t_yellow=0, t_all_red=0, request pending -> MAIN_YELLOW and ALL_RED_1 each last 1 tick, with cnt_value=0.
5. rst asserted during SIDE_GREEN with req_pending=1 -> next cycle phase=INIT, both lights 100, req_pending=0; following cycle MAIN_GREEN with cnt_value=4.
6. side_req held on the ALL_RED_1 to SIDE_GREEN edge, then pulsed in SIDE_GREEN -> req_pending 0 after that edge, 1 after the pulse. Side is served again after the next 5-tick MAIN_GREEN.
